// File: rtl/configurable_blinky_pkg.sv
// Shared constants for the UART-configured LED blinker: command bytes,
// parser states, register indices and register reset defaults.
package configurable_blinky_pkg;

   localparam logic [7:0] CMD_READ  = 8'h72;
   localparam logic [7:0] CMD_WRITE = 8'h77;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_VAL0,
      ST_VAL1,
      ST_VAL2,
      ST_VAL3,
      ST_EXEC
   } parse_state_t;

   localparam int REG_PERIOD = 0;
   localparam int REG_PAT_A  = 1;
   localparam int REG_PAT_B  = 2;
   localparam int REG_CTRL   = 3;

   localparam int REG_RST_N = 16;
   localparam logic [31:0] REG_RST [REG_RST_N] = '{
      32'd25_000_000, 32'h0000_0055, 32'h0000_00AA, 32'h0000_0001,
      32'h0, 32'h0, 32'h0, 32'h0,
      32'h0, 32'h0, 32'h0, 32'h0,
      32'h0, 32'h0, 32'h0, 32'h0
   };

   // Registers beyond the default table come up as zero.
   function automatic logic [31:0] reg_default(input int idx);
      logic [31:0] v;
      v = 32'h0;
      for (int k = 0; k < REG_RST_N; k++)
         if (k == idx) v = REG_RST[k];
      return v;
   endfunction

endpackage

// File: rtl/blinky_cmd_parser.sv
// Command-frame parser and register file. Optional inter-byte timeout is
// built in when CFG_BLINKY_TIMEOUT_EN is defined.
module blinky_cmd_parser
   import configurable_blinky_pkg::*;
#(
   parameter int REG_DEPTH = 16,
   parameter int REG_WIDTH = 32,
   parameter int TIMEOUT   = 5208
) (
   input  logic                 clk,
   input  logic                 i_reset,
   input  logic [7:0]           i_data,
   input  logic                 i_data_valid,
   output logic [7:0]           o_tx_data,
   output logic                 o_tx_wr,
   output logic [REG_WIDTH-1:0] o_half_period,
   output logic [7:0]           o_pat_a,
   output logic [7:0]           o_pat_b,
   output logic                 o_enable,
   output logic                 o_period_wr
);

   localparam int AW = $clog2(REG_DEPTH);

   parse_state_t         state_q, state_d;
   logic                 is_read_q;
   logic [7:0]           addr_q;
   logic [REG_WIDTH-1:0] val_q;
   logic [1:0]           rd_idx_q;
   logic [REG_WIDTH-1:0] regs [REG_DEPTH];
   logic [REG_WIDTH-1:0] rd_word, wr_word;
   logic                 addr_ok, val_byte, reg_we, to_hit;

   assign addr_ok  = 32'(addr_q) < REG_DEPTH;
   assign val_byte = i_data_valid && (state_q inside {ST_VAL0, ST_VAL1, ST_VAL2, ST_VAL3});
   assign wr_word  = {val_q[REG_WIDTH-9:0], i_data};
   // Writes commit on the edge that accepts the last value byte.
   assign reg_we   = (state_q == ST_VAL3) && i_data_valid && !is_read_q && addr_ok;
   assign rd_word  = addr_ok ? regs[addr_q[AW-1:0]] : '0;

`ifdef CFG_BLINKY_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] to_cnt;

   always_ff @(posedge clk) begin
      if (i_reset || state_q == ST_IDLE || i_data_valid) to_cnt <= '0;
      else if (to_cnt != TW'(TIMEOUT - 1))              to_cnt <= to_cnt + 1'b1;
   end

   assign to_hit = !(state_q inside {ST_IDLE, ST_EXEC}) && !i_data_valid &&
                   (to_cnt == TW'(TIMEOUT - 1));
`else
   assign to_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (i_reset) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      o_tx_wr   = 1'b0;
      o_tx_data = 8'h00;
      unique case (state_q)
         ST_IDLE: if (i_data_valid && (i_data == CMD_READ || i_data == CMD_WRITE))
                     state_d = ST_ADDR;
         ST_ADDR: if (i_data_valid) state_d = ST_VAL0;
         ST_VAL0: if (i_data_valid) state_d = ST_VAL1;
         ST_VAL1: if (i_data_valid) state_d = ST_VAL2;
         ST_VAL2: if (i_data_valid) state_d = ST_VAL3;
         ST_VAL3: if (i_data_valid) state_d = ST_EXEC;
         ST_EXEC: begin
            o_tx_wr = is_read_q;
            unique case (rd_idx_q)
               2'd0: o_tx_data = rd_word[31:24];
               2'd1: o_tx_data = rd_word[23:16];
               2'd2: o_tx_data = rd_word[15:8];
               2'd3: o_tx_data = rd_word[7:0];
            endcase
            if (!is_read_q || rd_idx_q == 2'd3) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (to_hit) state_d = ST_IDLE;
   end

   always_ff @(posedge clk) begin
      if (i_reset) begin
         is_read_q <= 1'b0;
         addr_q    <= '0;
         val_q     <= '0;
         rd_idx_q  <= '0;
         for (int i = 0; i < REG_DEPTH; i++) regs[i] <= REG_WIDTH'(reg_default(i));
      end else begin
         if (state_q == ST_IDLE && i_data_valid) is_read_q <= (i_data == CMD_READ);
         if (state_q == ST_ADDR && i_data_valid) addr_q <= i_data;
         if (val_byte) val_q <= wr_word;
         if (reg_we)   regs[addr_q[AW-1:0]] <= wr_word;
         rd_idx_q <= (state_q == ST_EXEC && is_read_q) ? rd_idx_q + 2'd1 : 2'd0;
      end
   end

   assign o_half_period = regs[REG_PERIOD];
   assign o_pat_a       = regs[REG_PAT_A][7:0];
   assign o_pat_b       = regs[REG_PAT_B][7:0];
   assign o_enable      = regs[REG_CTRL][0];
   assign o_period_wr   = reg_we && (32'(addr_q) == REG_PERIOD);

endmodule

// File: rtl/fifo_uart.sv
// Byte FIFO feeding a UART 8N1 transmitter. Writes to a full FIFO are dropped.
// With i_fifo_en, a burst still being written is held until LEVEL bytes queue.
module fifo_uart #(
   parameter int DIVISOR = 434,
   parameter int DEPTH   = 16,
   parameter int LEVEL   = 2
) (
   input  logic       clk,
   input  logic       i_reset,
   input  logic       i_wr,
   input  logic [7:0] i_data,
   input  logic       i_tx_en,
   input  logic       i_fifo_en,
   output logic       o_tx
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DIVISOR + 1);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   count;
   logic          push, pop;
   logic          busy;
   logic [8:0]    tx_sh;
   logic [3:0]    tx_bits;
   logic [CW-1:0] tx_cnt;

   assign push = i_wr && (32'(count) != DEPTH);
   assign pop  = !busy && i_tx_en && (count != '0) &&
                 (!i_fifo_en || !i_wr || 32'(count) >= LEVEL);

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= i_data;
   end

   always_ff @(posedge clk) begin
      if (i_reset) begin
         wptr    <= '0;
         rptr    <= '0;
         count   <= '0;
         busy    <= 1'b0;
         tx_sh   <= '1;
         tx_bits <= '0;
         tx_cnt  <= '0;
         o_tx    <= 1'b1;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
         if (pop) begin
            busy    <= 1'b1;
            o_tx    <= 1'b0;
            tx_sh   <= {1'b1, mem[rptr]};
            tx_bits <= 4'd9;
            tx_cnt  <= CW'(DIVISOR - 1);
         end else if (busy) begin
            if (tx_cnt != '0) begin
               tx_cnt <= tx_cnt - 1'b1;
            end else if (tx_bits != '0) begin
               o_tx    <= tx_sh[0];
               tx_sh   <= {1'b1, tx_sh[8:1]};
               tx_bits <= tx_bits - 1'b1;
               tx_cnt  <= CW'(DIVISOR - 1);
            end else begin
               busy <= 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: 2-flop input synchronizer, mid-bit sampling,
// one-cycle o_data_valid pulse per accepted byte.
module uart_rx #(
   parameter int DIVISOR       = 434,
   parameter int SAMPLE_PHASE  = DIVISOR / 2,
   parameter int LITTLE_ENDIAN = 1
) (
   input  logic       clk,
   input  logic       i_reset,
   input  logic       i_rx,
   output logic [7:0] o_data,
   output logic       o_data_valid
);

   localparam int CW = $clog2(DIVISOR + 1);

   logic          rx_s1, rx_s2;
   logic          busy;
   logic [3:0]    bit_idx;
   logic [CW-1:0] cnt;
   logic [7:0]    shreg;

   always_ff @(posedge clk) begin
      if (i_reset) begin
         rx_s1        <= 1'b1;
         rx_s2        <= 1'b1;
         busy         <= 1'b0;
         bit_idx      <= '0;
         cnt          <= '0;
         shreg        <= '0;
         o_data       <= '0;
         o_data_valid <= 1'b0;
      end else begin
         rx_s1        <= i_rx;
         rx_s2        <= rx_s1;
         o_data_valid <= 1'b0;
         if (!busy) begin
            if (!rx_s2) begin
               busy    <= 1'b1;
               bit_idx <= '0;
               cnt     <= CW'(SAMPLE_PHASE);
            end
         end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
         end else begin
            cnt     <= CW'(DIVISOR - 1);
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 4'd0) begin
               // a start bit that is high again at mid-bit was a glitch
               if (rx_s2) busy <= 1'b0;
            end else if (bit_idx == 4'd9) begin
               busy         <= 1'b0;
               o_data       <= shreg;
               o_data_valid <= rx_s2;
            end else if (LITTLE_ENDIAN != 0) begin
               shreg <= {rx_s2, shreg[7:1]};
            end else begin
               shreg <= {shreg[6:0], rx_s2};
            end
         end
      end
   end

endmodule

// File: rtl/configurable_blinky.sv
// LED pattern alternator configured over a UART register interface.
// Define CFG_BLINKY_TIMEOUT_EN to abandon partial frames after TIMEOUT clocks.
module configurable_blinky
   import configurable_blinky_pkg::*;
#(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUDRATE  = 115200,
   parameter int DIVISOR   = CLK_FREQ / BAUDRATE,
   parameter int REG_DEPTH = 16,
   parameter int REG_WIDTH = 32,
   parameter int TIMEOUT   = 10 * DIVISOR * 12
) (
   input  logic       clk,
   input  logic       i_reset,
   input  logic       i_rx,
   output logic       o_tx,
   input  logic [1:0] i_buttons,
   output logic [7:0] o_leds
);

   logic [7:0]           rx_data, tx_data, pat_a, pat_b;
   logic                 rx_valid, tx_wr, enable, period_wr;
   logic [REG_WIDTH-1:0] half_period, cnt;
   logic [1:0]           btn_s1, btn_s2;
   logic                 phase, run, wrap;

   uart_rx #(
      .DIVISOR      (DIVISOR),
      .SAMPLE_PHASE (DIVISOR / 2),
      .LITTLE_ENDIAN(1)
   ) u_rx (
      .clk         (clk),
      .i_reset     (i_reset),
      .i_rx        (i_rx),
      .o_data      (rx_data),
      .o_data_valid(rx_valid)
   );

   blinky_cmd_parser #(
      .REG_DEPTH(REG_DEPTH),
      .REG_WIDTH(REG_WIDTH),
      .TIMEOUT  (TIMEOUT)
   ) u_parser (
      .clk          (clk),
      .i_reset      (i_reset),
      .i_data       (rx_data),
      .i_data_valid (rx_valid),
      .o_tx_data    (tx_data),
      .o_tx_wr      (tx_wr),
      .o_half_period(half_period),
      .o_pat_a      (pat_a),
      .o_pat_b      (pat_b),
      .o_enable     (enable),
      .o_period_wr  (period_wr)
   );

   fifo_uart #(
      .DIVISOR(DIVISOR),
      .DEPTH  (16),
      .LEVEL  (2)
   ) u_tx (
      .clk      (clk),
      .i_reset  (i_reset),
      .i_wr     (tx_wr),
      .i_data   (tx_data),
      .i_tx_en  (1'b1),
      .i_fifo_en(1'b1),
      .o_tx     (o_tx)
   );

   always_ff @(posedge clk) begin
      if (i_reset) begin
         btn_s1 <= '0;
         btn_s2 <= '0;
      end else begin
         btn_s1 <= i_buttons;
         btn_s2 <= btn_s1;
      end
   end

   // A zero half-period stalls everything rather than wrapping every cycle.
   assign run  = enable && !btn_s2[0] && (half_period != '0);
   assign wrap = run && (cnt >= half_period - 1'b1);

   always_ff @(posedge clk) begin
      if (i_reset) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else begin
         if (period_wr || wrap) cnt <= '0;
         else if (run)          cnt <= cnt + 1'b1;
         if (wrap) phase <= ~phase;
      end
   end

   assign o_leds = btn_s2[1] ? 8'h00 : (phase ? pat_b : pat_a);

endmodule

// File: tb/tb_configurable_blinky.sv
// Randomized directed bench for configurable_blinky against a register/LED model.
module tb_configurable_blinky;

   localparam int DIV     = 8;
   localparam int TIMEOUT = 10 * DIV * 12;

   logic       clk = 1'b0;
   logic       i_reset = 1'b1;
   logic       i_rx = 1'b1;
   logic       o_tx;
   logic [1:0] i_buttons = 2'b00;
   logic [7:0] o_leds;

   int checks = 0;
   int failures = 0;
   logic [31:0] model [16];
   logic [7:0]  rx_q [$];

   configurable_blinky #(
      .CLK_FREQ (800_000),
      .BAUDRATE (100_000),
      .REG_DEPTH(16),
      .REG_WIDTH(32),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk      (clk),
      .i_reset  (i_reset),
      .i_rx     (i_rx),
      .o_tx     (o_tx),
      .i_buttons(i_buttons),
      .o_leds   (o_leds)
   );

   always #5 clk = ~clk;

   // UART monitor on o_tx, sampling at mid-bit on falling clock edges
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge o_tx);
         repeat (DIV / 2) @(negedge clk);
         for (int k = 0; k < 8; k++) begin
            repeat (DIV) @(negedge clk);
            b[k] = o_tx;
         end
         repeat (DIV) @(negedge clk);
         rx_q.push_back(b);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic reset_model();
      model[0] = 32'd25_000_000;
      model[1] = 32'h55;
      model[2] = 32'hAA;
      model[3] = 32'h1;
      for (int i = 4; i < 16; i++) model[i] = 32'h0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      i_rx = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         i_rx = b[k];
         repeat (DIV) @(negedge clk);
      end
      i_rx = 1'b1;
      repeat (DIV) @(negedge clk);
   endtask

   task automatic write_reg(input logic [7:0] addr, input logic [31:0] val);
      send_byte(8'h77);
      send_byte(addr);
      send_byte(val[31:24]);
      send_byte(val[23:16]);
      send_byte(val[15:8]);
      send_byte(val[7:0]);
      repeat (4) @(negedge clk);
      if (addr < 8'd16) model[addr[3:0]] = val;
   endtask

   task automatic read_reg(input string tag, input logic [7:0] addr, output logic [31:0] word);
      int t;
      logic [31:0] junk;
      rx_q.delete();
      junk = $urandom();
      send_byte(8'h72);
      send_byte(addr);
      for (int k = 3; k >= 0; k--) send_byte(junk[8*k +: 8]);
      t = 0;
      while (rx_q.size() < 4 && t < 1000) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_nbytes"}, rx_q.size(), 4);
      word = (rx_q.size() >= 4) ? {rx_q[0], rx_q[1], rx_q[2], rx_q[3]} : 32'hxxxx_xxxx;
   endtask

   // Waits for an LED change, then measures how long the new value persists.
   task automatic measure_run(input string tag, input int n, input logic [7:0] a,
                              input logic [7:0] b);
      logic [7:0] v;
      int t, len;
      v = o_leds;
      t = 0;
      while (o_leds === v && t < 4 * n + 20) begin
         @(negedge clk);
         t++;
      end
      v = o_leds;
      check({tag, "_val"}, 32'(v === a || v === b), 32'd1);
      len = 0;
      while (len < 4 * n + 20) begin
         @(negedge clk);
         len++;
         if (o_leds !== v) break;
      end
      check({tag, "_len"}, len, n);
   endtask

   initial begin
      logic [31:0] w, r;
      logic [7:0]  v;
      int          a;

      reset_model();
      repeat (5) @(negedge clk);
      i_reset = 1'b0;
      @(negedge clk);
      check("rst_leds", o_leds, 32'h55);
      check("rst_tx", o_tx, 32'h1);

      // fill every address plus one out of range
      for (int i = 0; i <= 16; i++) begin
         r = $urandom();
         write_reg(8'(i), {r[23:0], 8'(i)});
      end
      read_reg("rd10", 8'h0A, w);
      check("rd10", w, model[10]);
      read_reg("rd16", 8'h10, w);
      check("rd16", w, 32'h0);
      for (int k = 0; k < 3; k++) begin
         a = int'($urandom_range(15, 4));
         read_reg("rd_rand", 8'(a), w);
         check("rd_rand", w, model[a]);
      end

      write_reg(8'h01, 32'h0F);
      write_reg(8'h02, 32'hF0);
      write_reg(8'h03, 32'h1);
      write_reg(8'h00, 32'd10);
      measure_run("blink10a", 10, 8'h0F, 8'hF0);
      measure_run("blink10b", 10, 8'h0F, 8'hF0);
      write_reg(8'h00, 32'd4);
      measure_run("blink4", 4, 8'h0F, 8'hF0);
      write_reg(8'h00, 32'd10);

      // garbage byte is dropped, following frame still parsed
      send_byte(8'h41);
      write_reg(8'h03, 32'h0);
      v = o_leds;
      repeat (40) @(negedge clk);
      check("frozen", o_leds, v);
      read_reg("rd3", 8'h03, w);
      check("rd3", w, 32'h0);

      write_reg(8'h03, 32'h1);
      measure_run("reenable", 10, 8'h0F, 8'hF0);
      i_buttons = 2'b10;
      repeat (3) @(negedge clk);
      check("blank3", o_leds, 32'h0);
      repeat (25) @(negedge clk);
      check("blank_hold", o_leds, 32'h0);
      i_buttons = 2'b01;
      repeat (4) @(negedge clk);
      v = o_leds;
      check("unblank", 32'(v === 8'h0F || v === 8'hF0), 32'd1);
      repeat (30) @(negedge clk);
      check("paused", o_leds, v);
      i_buttons = 2'b00;
      measure_run("resume_a", 10, 8'h0F, 8'hF0);
      measure_run("resume_b", 10, 8'h0F, 8'hF0);

`ifdef CFG_BLINKY_TIMEOUT_EN
      send_byte(8'h77);
      send_byte(8'h05);
      send_byte(8'hDE);
      repeat (TIMEOUT + 50) @(negedge clk);
      read_reg("rd_to", 8'h05, w);
      check("timeout_keep", w, model[5]);
`endif

      // reset mid-frame
      send_byte(8'h77);
      send_byte(8'h02);
      send_byte(8'h12);
      i_reset = 1'b1;
      repeat (3) @(negedge clk);
      i_reset = 1'b0;
      reset_model();
      @(negedge clk);
      check("rst2_leds", o_leds, 32'h55);
      check("rst2_tx", o_tx, 32'h1);
      read_reg("rd0", 8'h00, w);
      check("rd0_default", w, model[0]);
      read_reg("rd2", 8'h02, w);
      check("rd2_default", w, model[2]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
